// File: rtl/serdes_host.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serdes_host
//
// Host-side driver for a byte-serial adder tile. It takes an operand pair
// {a, b} on a valid/ready request port and sends it MS byte first on bus_out,
// a then b. It then pulses start_calc, waits CALC_WAIT cycles, and raises
// output_result for N cycles. The N result bytes returned on bus_in are
// shifted into rsp_z and offered on a valid/ready response port.
//
// Parameters
//   WIDTH      operand/result width, multiple of 8 (N = WIDTH/8 bytes)
//   CALC_WAIT  idle cycles between start_calc and the first output_result
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   req_valid/req_ready/req_a/req_b   operand request handshake
//   rsp_valid/rsp_ready/rsp_z         result response handshake
//   bus_out        byte to device ui_in
//   start_calc     to device uio_in[2]
//   output_result  to device uio_in[3]
//   bus_in         byte from device uo_out
//
// Every output is a flop. Each output flop is loaded from a decode of the
// *next* state, so an output's value always matches the state it is in.
// -----------------------------------------------------------------------------
module serdes_host #(
   parameter int WIDTH     = 24,
   parameter int CALC_WAIT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [WIDTH-1:0]   req_a,
   input  logic [WIDTH-1:0]   req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WIDTH-1:0]   rsp_z,
   output logic [7:0]         bus_out,
   output logic               start_calc,
   output logic               output_result,
   input  logic [7:0]         bus_in
);

   localparam int N     = WIDTH / 8;
   localparam int CNT_W = $clog2(2 * N + 17);

   localparam logic [CNT_W-1:0] LAST_SEND = CNT_W'(2 * N - 1);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((CALC_WAIT > 0) ? (CALC_WAIT - 1) : 0);
   localparam logic [CNT_W-1:0] LAST_READ = CNT_W'(N);
   localparam logic [CNT_W-1:0] NUM_OR    = CNT_W'(N);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SEND  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_READ  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   sh_q, sh_d;
   logic [WIDTH-1:0]     rsp_z_q, rsp_z_d;
   logic [7:0]           bus_out_q, bus_out_d;
   logic                 start_calc_q, start_calc_d;
   logic                 output_result_q, output_result_d;
   logic                 req_ready_q, req_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;

   // State, counter, datapath and output flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         sh_q            <= '0;
         rsp_z_q         <= '0;
         bus_out_q       <= 8'h00;
         start_calc_q    <= 1'b0;
         output_result_q <= 1'b0;
         req_ready_q     <= 1'b1;
         rsp_valid_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         sh_q            <= sh_d;
         rsp_z_q         <= rsp_z_d;
         bus_out_q       <= bus_out_d;
         start_calc_q    <= start_calc_d;
         output_result_q <= output_result_d;
         req_ready_q     <= req_ready_d;
         rsp_valid_q     <= rsp_valid_d;
      end
   end

   // Next-state and phase counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            // req_ready is high exactly while idle, so valid alone is the handshake
            if (req_valid) begin
               state_d = S_SEND;
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEND: begin
            if (cnt_q == LAST_SEND) begin
               state_d = S_START;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_START: begin
            cnt_d = '0;
            if (CALC_WAIT == 0) begin
               state_d = S_READ;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == LAST_WAIT) begin
               state_d = S_READ;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_READ: begin
            if (cnt_q == LAST_READ) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Datapath and next values of the registered outputs
   always_comb begin
      sh_d    = sh_q;
      rsp_z_d = rsp_z_q;

      if ((state_q == S_IDLE) && (state_d == S_SEND)) begin
         sh_d = {req_a, req_b};
      end else if (state_q == S_SEND) begin
         sh_d = sh_q << 8;
      end else begin
         sh_d = sh_q;
      end

      // READ cycle 0 only launches output_result; the device answers one
      // cycle later, so bytes are taken in READ cycles 1..N.
      if ((state_q == S_READ) && (cnt_q != '0)) begin
         rsp_z_d = (rsp_z_q << 8) | WIDTH'(bus_in);
      end else begin
         rsp_z_d = rsp_z_q;
      end

      if (state_d == S_SEND) begin
         bus_out_d = sh_d[2*WIDTH-1 -: 8];
      end else begin
         bus_out_d = 8'h00;
      end

      start_calc_d    = (state_d == S_START);
      output_result_d = (state_d == S_READ) && (cnt_d < NUM_OR);
      req_ready_d     = (state_d == S_IDLE);
      rsp_valid_d     = (state_d == S_DONE);
   end

   assign req_ready     = req_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_z         = rsp_z_q;
   assign bus_out       = bus_out_q;
   assign start_calc    = start_calc_q;
   assign output_result = output_result_q;

endmodule

// File: tb/tb_serdes_host.sv
`timescale 1ns/1ps
// Directed bench for serdes_host: default build, CALC_WAIT=0 build and
// WIDTH=8 build, each with a small byte-serial device model.
module tb_serdes_host;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- default instance (WIDTH=24, CALC_WAIT=2) ----------------
   logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready;
   logic [23:0] d_req_a, d_req_b, d_rsp_z;
   logic [7:0]  d_bus_out, d_bus_in;
   logic        d_start, d_or;
   logic [7:0]  d_dev [0:2];
   int          d_idx;

   serdes_host #(.WIDTH(24), .CALC_WAIT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(d_req_valid), .req_ready(d_req_ready),
      .req_a(d_req_a), .req_b(d_req_b),
      .rsp_valid(d_rsp_valid), .rsp_ready(d_rsp_ready), .rsp_z(d_rsp_z),
      .bus_out(d_bus_out), .start_calc(d_start), .output_result(d_or),
      .bus_in(d_bus_in)
   );

   // Device model: after each output_result cycle present the next result byte
   always @(posedge clk) begin
      if (d_start) begin
         d_idx    <= 0;
         d_bus_in <= 8'hEE;
      end else if (d_or) begin
         d_bus_in <= d_dev[d_idx];
         d_idx    <= d_idx + 1;
      end
   end

   // ---------------- CALC_WAIT=0 instance ----------------
   logic        c_req_valid, c_req_ready, c_rsp_valid, c_rsp_ready;
   logic [23:0] c_req_a, c_req_b, c_rsp_z;
   logic [7:0]  c_bus_out, c_bus_in;
   logic        c_start, c_or;
   logic [7:0]  c_dev [0:2];
   int          c_idx;

   serdes_host #(.WIDTH(24), .CALC_WAIT(0)) dut_cw0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(c_req_valid), .req_ready(c_req_ready),
      .req_a(c_req_a), .req_b(c_req_b),
      .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready), .rsp_z(c_rsp_z),
      .bus_out(c_bus_out), .start_calc(c_start), .output_result(c_or),
      .bus_in(c_bus_in)
   );

   // Device model for the CALC_WAIT=0 instance
   always @(posedge clk) begin
      if (c_start) begin
         c_idx    <= 0;
         c_bus_in <= 8'hEE;
      end else if (c_or) begin
         c_bus_in <= c_dev[c_idx];
         c_idx    <= c_idx + 1;
      end
   end

   // ---------------- WIDTH=8 instance ----------------
   logic        w_req_valid, w_req_ready, w_rsp_valid, w_rsp_ready;
   logic [7:0]  w_req_a, w_req_b, w_rsp_z;
   logic [7:0]  w_bus_out, w_bus_in;
   logic        w_start, w_or;
   logic [7:0]  w_dev;

   serdes_host #(.WIDTH(8), .CALC_WAIT(2)) dut_w8 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(w_req_valid), .req_ready(w_req_ready),
      .req_a(w_req_a), .req_b(w_req_b),
      .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_z(w_rsp_z),
      .bus_out(w_bus_out), .start_calc(w_start), .output_result(w_or),
      .bus_in(w_bus_in)
   );

   // Device model for the WIDTH=8 instance
   always @(posedge clk) begin
      if (w_start) begin
         w_bus_in <= 8'hEE;
      end else if (w_or) begin
         w_bus_in <= w_dev;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] eb [0:5];

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0;
      d_req_valid = 1'b0; d_rsp_ready = 1'b0; d_req_a = 24'h0; d_req_b = 24'h0;
      c_req_valid = 1'b0; c_rsp_ready = 1'b1; c_req_a = 24'h0; c_req_b = 24'h0;
      w_req_valid = 1'b0; w_rsp_ready = 1'b1; w_req_a = 8'h0;  w_req_b = 8'h0;
      d_dev[0] = 8'h00; d_dev[1] = 8'h00; d_dev[2] = 8'h00;
      c_dev[0] = 8'h00; c_dev[1] = 8'h00; c_dev[2] = 8'h00;
      w_dev = 8'h00;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      check("rst req_ready", 64'(d_req_ready), 64'd1);
      check("rst rsp_valid", 64'(d_rsp_valid), 64'd0);
      check("rst rsp_z",     64'(d_rsp_z),     64'd0);
      check("rst bus_out",   64'(d_bus_out),   64'd0);
      check("rst start",     64'(d_start),     64'd0);
      check("rst or",        64'(d_or),        64'd0);
      check("rst w8 ready",  64'(w_req_ready), 64'd1);
      check("rst cw0 ready", 64'(c_req_ready), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- basic transaction with 5 cycles of backpressure ----
      d_dev[0] = 8'h21; d_dev[1] = 8'h43; d_dev[2] = 8'h65;
      eb[0] = 8'h12; eb[1] = 8'h34; eb[2] = 8'h56; eb[3] = 8'h0F; eb[4] = 8'h0F; eb[5] = 8'h0F;
      d_req_a = 24'h123456; d_req_b = 24'h0F0F0F; d_req_valid = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (c == 1) d_req_valid = 1'b0;
         check($sformatf("t1 bus c%0d", c), 64'(d_bus_out), (c <= 6) ? 64'(eb[c-1]) : 64'd0);
         check($sformatf("t1 start c%0d", c), 64'(d_start), 64'(c == 7));
         check($sformatf("t1 or c%0d", c), 64'(d_or), 64'((c >= 10) && (c <= 12)));
         check($sformatf("t1 rsp_valid c%0d", c), 64'(d_rsp_valid), 64'(c >= 14));
         check($sformatf("t1 req_ready c%0d", c), 64'(d_req_ready), 64'd0);
         if (c >= 14) check($sformatf("t1 rsp_z c%0d", c), 64'(d_rsp_z), 64'h214365);
      end
      d_rsp_ready = 1'b1;
      @(negedge clk);
      check("t2 idle req_ready", 64'(d_req_ready), 64'd1);
      check("t2 idle rsp_valid", 64'(d_rsp_valid), 64'd0);

      // ---- req_valid held high with changing operands ----
      d_dev[0] = 8'h05; d_dev[1] = 8'h07; d_dev[2] = 8'h09;
      eb[0] = 8'h01; eb[1] = 8'h02; eb[2] = 8'h03; eb[3] = 8'h04; eb[4] = 8'h05; eb[5] = 8'h06;
      d_req_a = 24'h010203; d_req_b = 24'h040506; d_req_valid = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (c == 1) begin
            d_req_a = 24'h111111; d_req_b = 24'h222222;
         end
         if (c <= 6) check($sformatf("t3 bus c%0d", c), 64'(d_bus_out), 64'(eb[c-1]));
         check($sformatf("t3 req_ready c%0d", c), 64'(d_req_ready), 64'(c == 15));
         check($sformatf("t3 rsp_valid c%0d", c), 64'(d_rsp_valid), 64'(c == 14));
         if (c == 14) begin
            check("t3 rsp_z first", 64'(d_rsp_z), 64'h050709);
            d_dev[0] = 8'h33; d_dev[1] = 8'h33; d_dev[2] = 8'h33;
         end
      end
      eb[0] = 8'h11; eb[1] = 8'h11; eb[2] = 8'h11; eb[3] = 8'h22; eb[4] = 8'h22; eb[5] = 8'h22;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (c == 1) begin
            d_req_valid = 1'b0;
            check("t3 second accepted", 64'(d_req_ready), 64'd0);
         end
         if (c <= 6) check($sformatf("t3b bus c%0d", c), 64'(d_bus_out), 64'(eb[c-1]));
         if (c == 14) begin
            check("t3b rsp_valid", 64'(d_rsp_valid), 64'd1);
            check("t3b rsp_z", 64'(d_rsp_z), 64'h333333);
         end
      end
      @(negedge clk);

      // ---- asynchronous reset during SEND byte 4 ----
      d_req_a = 24'hAABBCC; d_req_b = 24'hDDEEFF; d_req_valid = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) d_req_valid = 1'b0;
      end
      check("t4 bus byte4", 64'(d_bus_out), 64'hDD);
      #2 rst_n = 1'b0;
      #1;
      check("t4 async req_ready", 64'(d_req_ready), 64'd1);
      check("t4 async rsp_valid", 64'(d_rsp_valid), 64'd0);
      check("t4 async rsp_z",     64'(d_rsp_z),     64'd0);
      check("t4 async bus_out",   64'(d_bus_out),   64'd0);
      check("t4 async start",     64'(d_start),     64'd0);
      check("t4 async or",        64'(d_or),        64'd0);
      @(negedge clk);
      check("t4 in reset start", 64'(d_start), 64'd0);
      // release and present a request in the first cycle after release
      d_dev[0] = 8'h00; d_dev[1] = 8'h01; d_dev[2] = 8'hFF;
      eb[0] = 8'h7E; eb[1] = 8'h01; eb[2] = 8'h00; eb[3] = 8'h00; eb[4] = 8'h00; eb[5] = 8'hFF;
      d_req_a = 24'h7E0100; d_req_b = 24'h0000FF; d_req_valid = 1'b1;
      rst_n = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (c == 1) begin
            d_req_valid = 1'b0;
            check("t4 accept after release", 64'(d_req_ready), 64'd0);
         end
         if (c <= 6) check($sformatf("t4 bus c%0d", c), 64'(d_bus_out), 64'(eb[c-1]));
         check($sformatf("t4 start c%0d", c), 64'(d_start), 64'(c == 7));
         check($sformatf("t4 rsp_valid c%0d", c), 64'(d_rsp_valid), 64'(c == 14));
      end
      check("t4 rsp_z", 64'(d_rsp_z), 64'h0001FF);
      @(negedge clk);

      // ---- CALC_WAIT = 0 ----
      eb[0] = 8'hFF; eb[1] = 8'hFF; eb[2] = 8'hFF; eb[3] = 8'h00; eb[4] = 8'h00; eb[5] = 8'h01;
      c_req_a = 24'hFFFFFF; c_req_b = 24'h000001; c_req_valid = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) c_req_valid = 1'b0;
         if (c <= 6) check($sformatf("t5 bus c%0d", c), 64'(c_bus_out), 64'(eb[c-1]));
         check($sformatf("t5 start c%0d", c), 64'(c_start), 64'(c == 7));
         check($sformatf("t5 or c%0d", c), 64'(c_or), 64'((c >= 8) && (c <= 10)));
         check($sformatf("t5 rsp_valid c%0d", c), 64'(c_rsp_valid), 64'(c == 12));
      end
      check("t5 rsp_z", 64'(c_rsp_z), 64'd0);
      @(negedge clk);

      // ---- WIDTH = 8 ----
      w_dev = 8'hFF;
      w_req_a = 8'hA5; w_req_b = 8'h5A; w_req_valid = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) w_req_valid = 1'b0;
         check($sformatf("t6 bus c%0d", c), 64'(w_bus_out),
               (c == 1) ? 64'hA5 : ((c == 2) ? 64'h5A : 64'h00));
         check($sformatf("t6 start c%0d", c), 64'(w_start), 64'(c == 3));
         check($sformatf("t6 or c%0d", c), 64'(w_or), 64'(c == 6));
         check($sformatf("t6 rsp_valid c%0d", c), 64'(w_rsp_valid), 64'(c == 8));
      end
      check("t6 rsp_z", 64'(w_rsp_z), 64'hFF);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serdes_host.md
# serdes_host

Host-side driver for the byte-serial adder interface of the chip top level. It accepts a pair of WIDTH-bit operands over a valid/ready request port and serializes them onto the 8-bit input bus that feeds the operand deserializer. It then pulses `start_calc`, waits for the adder to settle, and raises `output_result` to collect the result bytes. The reassembled result is returned on a valid/ready response port. It sits in the FPGA test harness or companion controller that drives the tile's `ui_in`, `uio_in[3:2]` and `uo_out` pins.

## Interface
- `WIDTH`, 24: operand/result width; must be a multiple of 8. `N = WIDTH/8` bytes per word.
- `CALC_WAIT`, 2: idle cycles between the `start_calc` pulse and the first `output_result` cycle. Range 0..15.

- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  operand pair valid
- `req_ready`  out  1  block idle, can accept request
- `req_a`  in  WIDTH  operand a
- `req_b`  in  WIDTH  operand b
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_z`  out  WIDTH  result word
- `bus_out`  out  8  byte to device `ui_in`
- `start_calc`  out  1  to device `uio_in[2]`
- `output_result`  out  1  to device `uio_in[3]`
- `bus_in`  in  8  byte from device `uo_out`

## Operation
- States: IDLE, SEND, START, WAIT, READ, DONE.
- IDLE:
  - `req_ready`=1, `bus_out`=0.
  - On `req_valid && req_ready`, latch `{req_a, req_b}` into a 2·WIDTH shift register and go to SEND. Byte counter = 0.
- SEND: lasts 2N cycles, one byte per cycle, MS byte first.
  - Byte order: `a[W-1:W-8]` … `a[7:0]`, then `b[W-1:W-8]` … `b[7:0]`.
  - `start_calc`=0 and `output_result`=0 throughout. The device shifts `ui_in` every cycle while both are low.
- START: one cycle with `start_calc`=1 and `bus_out`=0.
- WAIT: CALC_WAIT cycles with all device controls low. When CALC_WAIT=0, go START→READ directly.
- READ: N+1 cycles.
  - `output_result`=1 in the first N cycles, 0 in the last.
  - The device presents result byte k (MS first) on `bus_in` in the cycle after the k-th `output_result` cycle.
  - Capture `bus_in` in READ cycles 1..N, shifting left into `rsp_z`.
- DONE:
  - `rsp_valid`=1 and `rsp_z` held stable until `rsp_ready`; then go to IDLE.
  - `req_valid` is ignored in every state except IDLE.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_z`=0, `bus_out`=0, `start_calc`=0, `output_result`=0, state IDLE.
- Assertion of `rst_n` in any state forces reset values immediately (asynchronous). The in-flight operation and partial result are discarded, and the device sees controls drop low.

## Timing
- All outputs are registered.
- With the request handshake on edge 0:
  - SEND drives cycles 1..2N.
  - `start_calc` is high in cycle 2N+1.
  - `output_result` is high in cycles 2N+2+CW..3N+1+CW.
  - `bus_in` is sampled in cycles 2N+3+CW..3N+2+CW.
  - `rsp_valid` rises in cycle 3N+3+CW. With defaults this is cycle 14.
- `req_ready` is low from cycle 1 until the cycle after the response handshake. Minimum request-to-request spacing is 3N+4+CW cycles when `rsp_ready` is tied high.
- Reset release: `req_ready`=1 on the first clock after `rst_n` rises. A request presented in that cycle is accepted.

## Test plan
- Default params. Request a=0x123456, b=0x0F0F0F. A device model returns 0x21, 0x43, 0x65.
  - Required: `bus_out` = 12,34,56,0F,0F,0F in cycles 1–6.
  - Required: `start_calc` high only in cycle 7 and `output_result` high in cycles 10–12.
  - Required: `rsp_valid` rises in cycle 14 with `rsp_z`=0x214365.
- Backpressure: `rsp_ready` low for 5 cycles after `rsp_valid`.
  - Required: `rsp_z` and `rsp_valid` are stable and `req_ready` stays 0.
  - Required: IDLE (`req_ready`=1) in the cycle after `rsp_ready` rises.
- `req_valid` held high with new operands throughout a transaction.
  - Required: the second request is accepted only in the IDLE cycle after the response handshake.
  - Required: the first result is unaffected.
- `rst_n` pulsed low in SEND byte 4.
  - Required: all outputs go to reset values without a clock edge and `start_calc` never pulses.
  - Required: a new request after release completes normally.
- CALC_WAIT=0, a=0xFFFFFF, b=0x000001, device returns 00,00,00.
  - Required: `output_result` is high in the cycle immediately after `start_calc`.
  - Required: `rsp_valid` in cycle 12 with `rsp_z`=0.
- WIDTH=8. a=0xA5, b=0x5A, device returns 0xFF.
  - Required: bytes A5, 5A, then `start_calc`.
  - Required: `rsp_z`=0xFF with `rsp_valid` in cycle 8.
